// File: rtl/rvfi_retire_packer_if.sv
// Execute-to-retirement handshake bundle feeding the RVFI packer.
// The master side is the execute stage; the slave side is the packer.
interface rvfi_retire_packer_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_insn;
  logic [31:0] ex_pc;
  logic [31:0] ex_pc_next;
  logic [4:0]  ex_rs1_addr;
  logic [4:0]  ex_rs2_addr;
  logic [31:0] ex_rs1_rdata;
  logic [31:0] ex_rs2_rdata;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_rd_wdata;
  logic        ex_trap;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [31:0] ex_mem_addr;
  logic [3:0]  ex_mem_mask;
  logic [31:0] ex_mem_wdata;

  modport master (
    output ex_valid, ex_insn, ex_pc, ex_pc_next,
    output ex_rs1_addr, ex_rs2_addr,
    output ex_rs1_rdata, ex_rs2_rdata,
    output ex_rd_addr, ex_rd_wdata, ex_trap,
    output ex_is_load, ex_is_store,
    output ex_mem_addr, ex_mem_mask, ex_mem_wdata,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_insn, ex_pc, ex_pc_next,
    input  ex_rs1_addr, ex_rs2_addr,
    input  ex_rs1_rdata, ex_rs2_rdata,
    input  ex_rd_addr, ex_rd_wdata, ex_trap,
    input  ex_is_load, ex_is_store,
    input  ex_mem_addr, ex_mem_mask, ex_mem_wdata,
    output ex_ready
  );
endinterface

// File: rtl/rvfi_retire_packer.sv
// RVFI retirement packer: one registered packet per retired/trapped insn.
// Loads park in WAIT_MEM until the LSU answers or the timeout fires.
module rvfi_retire_packer #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  rvfi_retire_packer_if.slave ex,
  input  logic        lsu_rvalid,
  input  logic        lsu_err,
  input  logic [31:0] lsu_rdata,
  output logic        rvfi_valid,
  output logic [63:0] rvfi_order,
  output logic [31:0] rvfi_insn,
  output logic [31:0] rvfi_pc_rdata,
  output logic [31:0] rvfi_pc_wdata,
  output logic        rvfi_trap,
  output logic        rvfi_halt,
  output logic        rvfi_intr,
  output logic [1:0]  rvfi_mode,
  output logic [1:0]  rvfi_ixl,
  output logic [4:0]  rvfi_rs1_addr,
  output logic [4:0]  rvfi_rs2_addr,
  output logic [4:0]  rvfi_rd_addr,
  output logic [31:0] rvfi_rs1_rdata,
  output logic [31:0] rvfi_rs2_rdata,
  output logic [31:0] rvfi_rd_wdata,
  output logic [31:0] rvfi_mem_addr,
  output logic [31:0] rvfi_mem_rdata,
  output logic [31:0] rvfi_mem_wdata,
  output logic [3:0]  rvfi_mem_rmask,
  output logic [3:0]  rvfi_mem_wmask,
  output logic [63:0] rvfi_ext_mcycle
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic        trap;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } pkt_t;

  localparam logic [31:0] TO_LAST = 32'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  pkt_t        hold_q, pkt_q, pkt_d;
  pkt_t        ex_pkt, ld_pkt;
  logic        emit, cap;
  logic [31:0] cnt_q, cnt_d;
  logic [63:0] ord_q, cyc_q;

  // Trap packets carry no architectural side effects.
  function automatic pkt_t fix(input pkt_t p);
    pkt_t r;
    r = p;
    if (r.trap) begin
      r.rd_addr   = '0;
      r.rd_wdata  = '0;
      r.mem_rmask = '0;
      r.mem_wmask = '0;
      r.mem_rdata = '0;
    end
    if (r.rd_addr == 5'd0) r.rd_wdata = '0;
    return r;
  endfunction

  assign ex.ex_ready = (state_q == IDLE);

  always_comb begin
    ex_pkt           = '0;
    ex_pkt.insn      = ex.ex_insn;
    ex_pkt.pc_rdata  = ex.ex_pc;
    ex_pkt.pc_wdata  = ex.ex_pc_next;
    ex_pkt.trap      = ex.ex_trap;
    ex_pkt.rs1_addr  = ex.ex_rs1_addr;
    ex_pkt.rs2_addr  = ex.ex_rs2_addr;
    ex_pkt.rs1_rdata = ex.ex_rs1_rdata;
    ex_pkt.rs2_rdata = ex.ex_rs2_rdata;
    ex_pkt.rd_addr   = ex.ex_rd_addr;
    ex_pkt.rd_wdata  = ex.ex_rd_wdata;
    ex_pkt.mem_addr  = ex.ex_mem_addr;
    ex_pkt.mem_wdata = ex.ex_mem_wdata;
    ex_pkt.mem_wmask = ex.ex_is_store ? ex.ex_mem_mask : 4'd0;
    ld_pkt           = ex_pkt;
    ld_pkt.mem_rmask = ex.ex_mem_mask;
    ld_pkt.rd_wdata  = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    cap     = 1'b0;
    pkt_d   = fix(ex_pkt);
    case (state_q)
      IDLE: begin
        if (ex.ex_valid) begin
          if (ex.ex_is_load && !ex.ex_trap) begin
            cap     = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_MEM;
          end else begin
            emit = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        cnt_d = cnt_q + 32'd1;
        pkt_d = hold_q;
        // A response on the timeout cycle wins over the timeout.
        if (lsu_rvalid) begin
          emit    = 1'b1;
          state_d = IDLE;
          if (lsu_err) begin
            pkt_d.trap = 1'b1;
          end else begin
            pkt_d.rd_wdata  = lsu_rdata;
            pkt_d.mem_rdata = lsu_rdata;
          end
          pkt_d = fix(pkt_d);
        end else if (cnt_q == TO_LAST) begin
          emit       = 1'b1;
          state_d    = IDLE;
          pkt_d.trap = 1'b1;
          pkt_d      = fix(pkt_d);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) hold_q <= ld_pkt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvfi_valid      <= 1'b0;
      rvfi_order      <= '0;
      rvfi_ext_mcycle <= '0;
      pkt_q           <= '0;
      ord_q           <= '0;
      cyc_q           <= '0;
    end else begin
      rvfi_valid <= emit;
      cyc_q      <= cyc_q + 64'd1;
      if (emit) begin
        pkt_q           <= pkt_d;
        rvfi_order      <= ord_q;
        rvfi_ext_mcycle <= cyc_q;
        ord_q           <= ord_q + 64'd1;
      end
    end
  end

  assign rvfi_halt      = 1'b0;
  assign rvfi_intr      = 1'b0;
  assign rvfi_mode      = 2'b11;
  assign rvfi_ixl       = 2'b01;
  assign rvfi_insn      = pkt_q.insn;
  assign rvfi_pc_rdata  = pkt_q.pc_rdata;
  assign rvfi_pc_wdata  = pkt_q.pc_wdata;
  assign rvfi_trap      = pkt_q.trap;
  assign rvfi_rs1_addr  = pkt_q.rs1_addr;
  assign rvfi_rs2_addr  = pkt_q.rs2_addr;
  assign rvfi_rd_addr   = pkt_q.rd_addr;
  assign rvfi_rs1_rdata = pkt_q.rs1_rdata;
  assign rvfi_rs2_rdata = pkt_q.rs2_rdata;
  assign rvfi_rd_wdata  = pkt_q.rd_wdata;
  assign rvfi_mem_addr  = pkt_q.mem_addr;
  assign rvfi_mem_rdata = pkt_q.mem_rdata;
  assign rvfi_mem_wdata = pkt_q.mem_wdata;
  assign rvfi_mem_rmask = pkt_q.mem_rmask;
  assign rvfi_mem_wmask = pkt_q.mem_wmask;

endmodule

// File: tb/tb_rvfi_retire_packer.sv
// Directed bench for rvfi_retire_packer with MEM_TIMEOUT=8.
// Drives and samples on the falling edge.
module tb_rvfi_retire_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_rvalid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
  logic [63:0] rvfi_order, rvfi_ext_mcycle;
  logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata;
  logic [1:0]  rvfi_mode, rvfi_ixl;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  int errs = 0;
  int checks = 0;

  rvfi_retire_packer_if ex_if ();

  rvfi_retire_packer #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .reset(rst_n), .ex(ex_if.slave),
    .lsu_rvalid(lsu_rvalid), .lsu_err(lsu_err),
    .lsu_rdata(lsu_rdata),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_trap(rvfi_trap),
    .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_ext_mcycle(rvfi_ext_mcycle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc,
                       input logic [31:0] pcn,
                       input logic [4:0]  rd,
                       input logic [31:0] wd,
                       input logic tr, ld, st,
                       input logic [3:0]  mask,
                       input logic [31:0] maddr,
                       input logic [31:0] mwd);
    ex_if.ex_valid     = 1'b1;
    ex_if.ex_insn      = pc ^ 32'h13;
    ex_if.ex_pc        = pc;
    ex_if.ex_pc_next   = pcn;
    ex_if.ex_rs1_addr  = 5'd1;
    ex_if.ex_rs2_addr  = 5'd2;
    ex_if.ex_rs1_rdata = 32'hA1;
    ex_if.ex_rs2_rdata = 32'hB2;
    ex_if.ex_rd_addr   = rd;
    ex_if.ex_rd_wdata  = wd;
    ex_if.ex_trap      = tr;
    ex_if.ex_is_load   = ld;
    ex_if.ex_is_store  = st;
    ex_if.ex_mem_mask  = mask;
    ex_if.ex_mem_addr  = maddr;
    ex_if.ex_mem_wdata = mwd;
  endtask

  initial begin
    ex_if.ex_valid = 1'b0;
    drive(0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    ex_if.ex_valid = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_err    = 1'b0;
    lsu_rdata  = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(rvfi_valid), 0);
    chk("rst_order", rvfi_order, 0);
    chk("rst_mcycle", rvfi_ext_mcycle, 0);
    chk("rst_ready", 64'(ex_if.ex_ready), 1);
    chk("rst_mode", 64'(rvfi_mode), 3);
    chk("rst_ixl", 64'(rvfi_ixl), 1);
    chk("rst_pc", 64'(rvfi_pc_rdata), 0);
    chk("rst_wdata", 64'(rvfi_rd_wdata), 0);

    // three back-to-back ALU ops
    rst_n = 1'b1;
    drive(32'h10, 32'h14, 5, 32'h11, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu0_valid", 64'(rvfi_valid), 1);
    chk("alu0_order", rvfi_order, 0);
    chk("alu0_wdata", 64'(rvfi_rd_wdata), 32'h11);
    chk("alu0_mcycle", rvfi_ext_mcycle, 0);
    chk("alu0_rs1", 64'(rvfi_rs1_rdata), 32'hA1);
    chk("alu0_masks", 64'({rvfi_mem_rmask, rvfi_mem_wmask}), 0);
    drive(32'h14, 32'h18, 5, 32'h22, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu1_valid", 64'(rvfi_valid), 1);
    chk("alu1_order", rvfi_order, 1);
    chk("alu1_wdata", 64'(rvfi_rd_wdata), 32'h22);
    chk("alu1_mcycle", rvfi_ext_mcycle, 1);
    drive(32'h18, 32'h1C, 5, 32'h33, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alu2_valid", 64'(rvfi_valid), 1);
    chk("alu2_order", rvfi_order, 2);
    chk("alu2_wdata", 64'(rvfi_rd_wdata), 32'h33);
    chk("alu2_pcw", 64'(rvfi_pc_wdata), 32'h1C);
    ex_if.ex_valid = 1'b0;
    @(negedge clk);
    chk("alu_pulse", 64'(rvfi_valid), 0);

    // load answered 4 cycles after accept
    drive(32'h100, 32'h104, 3, 32'h0, 0, 1, 0, 4'hF, 32'h200, 0);
    @(negedge clk);
    ex_if.ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ld_ready", 64'(ex_if.ex_ready), 0);
      chk("ld_wait", 64'(rvfi_valid), 0);
      @(negedge clk);
    end
    chk("ld_ready", 64'(ex_if.ex_ready), 0);
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    lsu_rvalid = 1'b0;
    chk("ld_valid", 64'(rvfi_valid), 1);
    chk("ld_order", rvfi_order, 3);
    chk("ld_rmask", 64'(rvfi_mem_rmask), 4'hF);
    chk("ld_mrdata", 64'(rvfi_mem_rdata), 32'hDEADBEEF);
    chk("ld_wdata", 64'(rvfi_rd_wdata), 32'hDEADBEEF);
    chk("ld_pc", 64'(rvfi_pc_rdata), 32'h100);
    chk("ld_maddr", 64'(rvfi_mem_addr), 32'h200);
    chk("ld_trap", 64'(rvfi_trap), 0);
    chk("ld_ready_back", 64'(ex_if.ex_ready), 1);

    // stray response in IDLE is ignored
    lsu_rvalid = 1'b1;
    @(negedge clk);
    lsu_rvalid = 1'b0;
    chk("idle_rvalid", 64'(rvfi_valid), 0);

    drive(32'h200, 32'h204, 0, 0, 0, 0, 1, 4'b0011, 32'h300, 32'hABCD);
    @(negedge clk);
    chk("st_valid", 64'(rvfi_valid), 1);
    chk("st_order", rvfi_order, 4);
    chk("st_wmask", 64'(rvfi_mem_wmask), 4'b0011);
    chk("st_rmask", 64'(rvfi_mem_rmask), 0);
    chk("st_mwdata", 64'(rvfi_mem_wdata), 32'hABCD);

    drive(32'h204, 32'h208, 0, 32'h99, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("x0_order", rvfi_order, 5);
    chk("x0_wdata", 64'(rvfi_rd_wdata), 0);

    // load bus error
    drive(32'h208, 32'h80, 9, 0, 0, 1, 0, 4'hF, 32'h400, 0);
    @(negedge clk);
    ex_if.ex_valid = 1'b0;
    lsu_rvalid = 1'b1;
    lsu_err    = 1'b1;
    lsu_rdata  = 32'h5555;
    @(negedge clk);
    lsu_rvalid = 1'b0;
    lsu_err    = 1'b0;
    chk("err_valid", 64'(rvfi_valid), 1);
    chk("err_trap", 64'(rvfi_trap), 1);
    chk("err_order", rvfi_order, 6);
    chk("err_rd", 64'(rvfi_rd_addr), 0);
    chk("err_wdata", 64'(rvfi_rd_wdata), 0);
    chk("err_masks", 64'({rvfi_mem_rmask, rvfi_mem_wmask}), 0);
    chk("err_mrdata", 64'(rvfi_mem_rdata), 0);
    chk("err_pcw", 64'(rvfi_pc_wdata), 32'h80);

    // execute-stage trap
    drive(32'h20C, 32'h90, 7, 32'h77, 1, 0, 1, 4'hF, 0, 1);
    @(negedge clk);
    ex_if.ex_valid = 1'b0;
    chk("trap_valid", 64'(rvfi_valid), 1);
    chk("trap_trap", 64'(rvfi_trap), 1);
    chk("trap_order", rvfi_order, 7);
    chk("trap_rd", 64'(rvfi_rd_addr), 0);
    chk("trap_wmask", 64'(rvfi_mem_wmask), 0);
    chk("trap_pcw", 64'(rvfi_pc_wdata), 32'h90);

    // load timeout
    drive(32'h300, 32'hA0, 4, 0, 0, 1, 0, 4'h3, 32'h500, 0);
    @(negedge clk);
    ex_if.ex_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("to_wait", 64'(rvfi_valid), 0);
      @(negedge clk);
    end
    chk("to_valid", 64'(rvfi_valid), 1);
    chk("to_trap", 64'(rvfi_trap), 1);
    chk("to_order", rvfi_order, 8);
    chk("to_rmask", 64'(rvfi_mem_rmask), 0);
    chk("to_pcw", 64'(rvfi_pc_wdata), 32'hA0);

    // response on the timeout cycle wins
    drive(32'h304, 32'h308, 6, 0, 0, 1, 0, 4'h1, 32'h600, 0);
    @(negedge clk);
    ex_if.ex_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("race_wait", 64'(rvfi_valid), 0);
      @(negedge clk);
    end
    lsu_rvalid = 1'b1;
    lsu_rdata  = 32'h1234;
    @(negedge clk);
    lsu_rvalid = 1'b0;
    chk("race_valid", 64'(rvfi_valid), 1);
    chk("race_trap", 64'(rvfi_trap), 0);
    chk("race_order", rvfi_order, 9);
    chk("race_wdata", 64'(rvfi_rd_wdata), 32'h1234);
    chk("race_rmask", 64'(rvfi_mem_rmask), 4'h1);

    // reset while a load is pending
    drive(32'h400, 32'h404, 8, 0, 0, 1, 0, 4'hF, 32'h700, 0);
    @(negedge clk);
    ex_if.ex_valid = 1'b0;
    chk("pend_ready", 64'(ex_if.ex_ready), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(rvfi_valid), 0);
    chk("mid_rst_ready", 64'(ex_if.ex_ready), 1);
    chk("mid_rst_order", rvfi_order, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h500, 32'h504, 4, 32'h55, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    ex_if.ex_valid = 1'b0;
    chk("post_valid", 64'(rvfi_valid), 1);
    chk("post_order", rvfi_order, 0);
    chk("post_mcycle", rvfi_ext_mcycle, 0);
    chk("post_wdata", 64'(rvfi_rd_wdata), 32'h55);
    chk("post_pc", 64'(rvfi_pc_rdata), 32'h500);
    @(negedge clk);
    chk("post_pulse", 64'(rvfi_valid), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
